// File: rtl/vga_scanout.sv
// VGA scan-out engine: timing generator, registered sync/enable outputs and a
// dual-clock pixel FIFO that feeds the first ACTIVE_LINES lines of each frame.
module vga_scanout #(
  parameter int H_DISP = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_DISP = 350,
  parameter int V_FP = 37,
  parameter int V_SYNC = 2,
  parameter int V_BP = 60,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int BPC = 4,
  parameter int FIFO_AW = 8,
  parameter int ACTIVE_LINES = 320,
  parameter logic [3*BPC-1:0] BORDER_RGB = '0
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               wr_clk,
  input  logic               wr_en,
  input  logic [3*BPC-1:0]   wr_data,
  output logic               wr_full,
  output logic [FIFO_AW:0]   wr_usedw,
  output logic               hsync,
  output logic               vsync,
  output logic               de_out,
  output logic [BPC-1:0]     vga_r,
  output logic [BPC-1:0]     vga_g,
  output logic [BPC-1:0]     vga_b,
  output logic               line_req,
  output logic               frame_start,
  output logic               underflow
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_DISP_C = 12'(H_DISP);
  localparam logic [11:0] V_DISP_C = 12'(V_DISP);
  localparam logic [11:0] HS_START = 12'(H_DISP + H_FP);
  localparam logic [11:0] HS_END = 12'(H_DISP + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_DISP + V_FP);
  localparam logic [11:0] VS_END = 12'(V_DISP + V_FP + V_SYNC);
  localparam logic [11:0] ACTIVE_C = 12'(ACTIVE_LINES);
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  function automatic logic [FIFO_AW:0] bin2gray(input logic [FIFO_AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FIFO_AW:0] gray2bin(input logic [FIFO_AW:0] g);
    logic [FIFO_AW:0] b;
    b[FIFO_AW] = g[FIFO_AW];
    for (int i = FIFO_AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------- FIFO storage and write side (wr_clk) ----------------
  // Write handshake: a word is taken on every wr_clk edge with wr_en high and
  // wr_full low; a write presented while wr_full is high is silently dropped.
  logic [3*BPC-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_bin, wr_gray, rd_gray_w1, rd_gray_w2;
  logic [FIFO_AW:0] rd_bin, rd_gray, wr_gray_r1, wr_gray_r2;
  logic             wr_accept;
  logic             rd_empty;

  assign wr_usedw  = wr_bin - gray2bin(rd_gray_w2);
  assign wr_full   = (wr_usedw == DEPTH_C);
  assign wr_accept = wr_en && !wr_full;

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      wr_bin     <= '0;
      wr_gray    <= '0;
      rd_gray_w1 <= '0;
      rd_gray_w2 <= '0;
    end else begin
      if (wr_accept) begin
        wr_bin  <= wr_bin + PTR_ONE;
        wr_gray <= bin2gray(wr_bin + PTR_ONE);
      end
      rd_gray_w1 <= rd_gray;
      rd_gray_w2 <= rd_gray_w1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) mem[wr_bin[FIFO_AW-1:0]] <= wr_data;
  end

  // ---------------- scan timing (vga_clk) ----------------
  logic [11:0] h, v, v_next;
  logic        de, hs_act, vs_act, fetch, rd_en, line_req_c, at_origin;
  logic [3*BPC-1:0] pixel;

  assign rd_empty   = (rd_gray == wr_gray_r2);
  assign de         = (h < H_DISP_C) && (v < V_DISP_C);
  assign hs_act     = (h >= HS_START) && (h < HS_END);
  assign vs_act     = (v >= VS_START) && (v < VS_END);
  assign fetch      = de && (v < ACTIVE_C);
  assign rd_en      = fetch && !rd_empty;
  assign v_next     = (v == V_LAST) ? 12'd0 : v + 12'd1;
  assign line_req_c = (h == H_DISP_C) && (v_next < ACTIVE_C);
  assign at_origin  = (h == 12'd0) && (v == 12'd0);
  assign {vga_r, vga_g, vga_b} = pixel;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h          <= '0;
      v          <= '0;
      rd_bin     <= '0;
      rd_gray    <= '0;
      wr_gray_r1 <= '0;
      wr_gray_r2 <= '0;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= v_next;
      end else begin
        h <= h + 12'd1;
      end
      if (rd_en) begin
        rd_bin  <= rd_bin + PTR_ONE;
        rd_gray <= bin2gray(rd_bin + PTR_ONE);
      end
      wr_gray_r1 <= wr_gray;
      wr_gray_r2 <= wr_gray_r1;
    end
  end

  // Every output describes the counter position of the previous cycle, so the
  // FIFO word read at (h,v) lands in pixel together with de_out for (h,v).
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de_out      <= 1'b0;
      line_req    <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      pixel       <= '0;
    end else begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de_out      <= de;
      line_req    <= line_req_c;
      frame_start <= at_origin;
      if (rd_en)            pixel <= mem[rd_bin[FIFO_AW-1:0]];
      else if (de && !fetch) pixel <= BORDER_RGB;
      else                  pixel <= '0;
      if (fetch && rd_empty) underflow <= 1'b1;
      else if (at_origin)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a shrunken raster: a position/queue model of the
// scan rules is compared on every cycle, plus directed literal checks.
module tb_vga_scanout;
  localparam int HD = 16, HFP = 2, HSY = 4, HBP = 3;
  localparam int VD = 10, VFP = 2, VSY = 2, VBP = 4;
  localparam int HT = HD + HFP + HSY + HBP;  // 25
  localparam int VT = VD + VFP + VSY + VBP;  // 18
  localparam int AL = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam logic [11:0] BORDER = 12'hF0F;

  logic        vga_clk, wr_clk, reset, wr_en;
  logic [11:0] wr_data;
  logic        wr_full;
  logic [8:0]  wr_usedw;
  logic        hsync, vsync, de_out, line_req, frame_start, underflow;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_scanout #(
    .H_DISP(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .BPC(4), .FIFO_AW(AW),
    .ACTIVE_LINES(AL), .BORDER_RGB(BORDER)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .wr_clk(wr_clk), .wr_en(wr_en),
    .wr_data(wr_data), .wr_full(wr_full), .wr_usedw(wr_usedw),
    .hsync(hsync), .vsync(vsync), .de_out(de_out),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .line_req(line_req), .frame_start(frame_start), .underflow(underflow)
  );

  // ---------------- clock/reset ----------------
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;
  initial wr_clk = 1'b0;
  always #3 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model state / scoreboard ----------------
  logic [11:0] exp_q[$];
  int cur_h, cur_v;
  logic m_uf;
  event tick;
  int st_hs, st_vs, st_de, st_lr;
  bit st_armed;
  int last_hs, last_vs, last_de, last_lr, frames_seen;
  logic [11:0] first_rgb, px15_rgb, last_read;

  logic [11:0] rgb_act, e_rgb;
  logic e_de, e_hs, e_vs, e_fetch, e_lr, e_fs, set_uf, popped;

  always @(negedge vga_clk) begin
    rgb_act = {vga_r, vga_g, vga_b};
    if (!reset) begin
      exp_q.delete();
      cur_h = 0; cur_v = 0; m_uf = 1'b0;
      st_armed = 0; st_hs = 0; st_vs = 0; st_de = 0; st_lr = 0;
      check("rst_hsync", hsync, 1); check("rst_vsync", vsync, 1);
      check("rst_de", de_out, 0); check("rst_fs", frame_start, 0);
      check("rst_lr", line_req, 0); check("rst_rgb", rgb_act, 0);
      check("rst_uf", underflow, 0); check("rst_full", wr_full, 0);
      check("rst_usedw", wr_usedw, 0);
    end else begin
      e_de    = (cur_h < HD) && (cur_v < VD);
      e_hs    = (cur_h >= HD + HFP) && (cur_h < HD + HFP + HSY);
      e_vs    = (cur_v >= VD + VFP) && (cur_v < VD + VFP + VSY);
      e_fetch = e_de && (cur_v < AL);
      e_lr    = (cur_h == HD) && (((cur_v + 1) % VT) < AL);
      e_fs    = (cur_h == 0) && (cur_v == 0);
      set_uf  = e_fetch && (exp_q.size() == 0);
      popped  = 1'b0;
      if (e_fetch) begin
        if (exp_q.size() > 0) begin e_rgb = exp_q.pop_front(); popped = 1'b1; end
        else e_rgb = 12'h000;
      end else if (e_de) e_rgb = BORDER;
      else e_rgb = 12'h000;
      if (set_uf) m_uf = 1'b1;
      else if (e_fs) m_uf = 1'b0;
      check("hsync", hsync, e_hs ? 0 : 1);
      check("vsync", vsync, e_vs ? 0 : 1);
      check("de_out", de_out, e_de);
      check("line_req", line_req, e_lr);
      check("frame_start", frame_start, e_fs);
      check("rgb", rgb_act, e_rgb);
      check("underflow", underflow, m_uf);
      if (popped) last_read = rgb_act;
      if (cur_h == 15 && cur_v == 0) px15_rgb = rgb_act;
      // Frame statistics are gathered from the DUT outputs themselves.
      if (frame_start) begin
        if (st_armed) begin
          last_hs = st_hs; last_vs = st_vs; last_de = st_de; last_lr = st_lr;
          frames_seen++;
        end
        st_armed = 1; st_hs = 0; st_vs = 0; st_de = 0; st_lr = 0;
        first_rgb = rgb_act;
      end
      if (st_armed) begin
        st_hs += int'(!hsync); st_vs += int'(!vsync);
        st_de += int'(de_out); st_lr += int'(line_req);
      end
      cur_h++;
      if (cur_h == HT) begin cur_h = 0; cur_v = (cur_v + 1) % VT; end
    end
    -> tick;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input int th, input int tv);
    int n;
    n = 0;
    do begin @(tick); n++; end
    while (!(cur_h == th && cur_v == tv) && n < 2 * HT * VT + 5);
    if (!(cur_h == th && cur_v == tv)) check("wait_pos_timeout", 0, 1);
  endtask

  task automatic write_words(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wr_clk);
      wr_en = 1'b1;
      wr_data = base + 12'(i);
      @(posedge wr_clk);
      if (exp_q.size() < DEPTH) exp_q.push_back(base + 12'(i));
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (30000) @(posedge vga_clk);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    frames_seen = 0; last_read = 12'h000; first_rgb = 12'h000; px15_rgb = 12'h000;
    last_hs = 0; last_vs = 0; last_de = 0; last_lr = 0;
    reset = 1'b0; wr_en = 1'b0; wr_data = 12'h000;
    repeat (5) @(tick);
    #1 reset = 1'b1;

    // Frame 0: nothing written, every fetch underflows.
    wait_pos(0, 8);
    check("f0_underflow", underflow, 1);
    check("f0_first_rgb", first_rgb, 12'h000);
    write_words(12'h001, 128);

    // Frame 1: fed exactly, frame 0 statistics available.
    wait_pos(0, 8);
    check("frames_seen", frames_seen, 1);
    check("hsync_low_per_frame", last_hs, 72);
    check("vsync_low_per_frame", last_vs, 50);
    check("de_per_frame", last_de, 160);
    check("line_req_per_frame", last_lr, 8);
    check("f1_first_rgb", first_rgb, 12'h001);
    check("f1_px15_rgb", px15_rgb, 12'h010);
    check("f1_last_read", last_read, 12'h080);
    check("f1_underflow", underflow, 0);
    check("f1_usedw_drained", wr_usedw, 0);

    // Overfill: the 257th word must be dropped.
    write_words(12'h400, 257);
    check("full_flag", wr_full, 1);
    check("full_usedw", wr_usedw, 256);
    wait_pos(24, 17);
    check("border_no_reads", wr_usedw, 256);

    wait_pos(0, 8);
    check("f2_first_rgb", first_rgb, 12'h400);
    check("f2_usedw", wr_usedw, 128);
    check("f2_full_clear", wr_full, 0);
    wait_pos(0, 8);
    check("f3_underflow", underflow, 0);
    check("f3_usedw", wr_usedw, 0);
    wait_pos(0, 8);
    check("f4_last_read", last_read, 12'h4FF);
    check("f4_underflow", underflow, 1);

    // Mid-frame reset with the FIFO half full.
    write_words(12'h600, 128);
    wait_pos(10, 12);
    check("pre_reset_usedw", wr_usedw, 128);
    #1 reset = 1'b0;
    @(tick);
    check("mid_rst_usedw", wr_usedw, 0);
    check("mid_rst_de", de_out, 0);
    check("mid_rst_hsync", hsync, 1);
    repeat (2) @(tick);
    #1 reset = 1'b1;
    @(negedge vga_clk);
    check("fs_after_release", frame_start, 1);
    wait_pos(0, 8);
    check("post_rst_usedw", wr_usedw, 0);
    check("post_rst_underflow", underflow, 1);
    wait_pos(0, 8);
    check("post_rst_line_req", last_lr, 8);
    check("post_rst_de", last_de, 160);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
